// File: rtl/mmu_cache_pkg.sv
// Shared types and default widths for the parametrised direct-mapped cache.
// Optional statistics counters are enabled by defining CACHE_STATS_EN.
package mmu_cache_pkg;

    localparam int DEF_INDEX_W = 11;
    localparam int DEF_TAG_W   = 14;
    localparam int DEF_DATA_W  = 16;

    // Upper bound on TAG_W; the in-flight request stores its tag at this width.
    localparam int MAX_TAG_W   = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } cache_state_t;

    typedef struct packed {
        logic                 pend;
        logic                 vld;
        logic [MAX_TAG_W-1:0] tag;
    } lk_req_t;

endpackage

// File: rtl/mmu_cache_dm_param_line_ram.sv
// Single-port {tag,data} line store, synchronous read, read-before-write.
module mmu_cache_line_ram #(
    parameter int AW = 11,
    parameter int DW = 30
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mmu_cache_dm_param.sv
// Direct-mapped cache with a clear sweep and one-cycle registered lookup.
// Define CACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module mmu_cache_dm_param
    import mmu_cache_pkg::*;
#(
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic               sysclk,
    input  logic               sys_rst_n,
    input  logic               lk_valid,
    output logic               lk_ready,
    input  logic [INDEX_W-1:0] lk_idx,
    input  logic [TAG_W-1:0]   lk_tag,
    output logic               res_valid,
    output logic               res_hit,
    output logic [DATA_W-1:0]  res_data,
    input  logic               upd_valid,
    input  logic [INDEX_W-1:0] upd_idx,
    input  logic [TAG_W-1:0]   upd_tag,
    input  logic [DATA_W-1:0]  upd_data,
    input  logic               brk_n,
    input  logic               con,
    input  logic               wcinh_n,
    input  logic               cclr_n,
    output logic               busy,
    output cache_state_t       state
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]        hit_cnt,
    output logic [31:0]        miss_cnt
`endif
);

    localparam int LINES = 2**INDEX_W;
    localparam logic [INDEX_W-1:0] LAST_IDX = '1;

    cache_state_t        state_q;
    logic [INDEX_W-1:0]  sweep_cnt;
    logic [LINES-1:0]    valid_q;
    lk_req_t             req_q;
    logic [TAG_W-1:0]    rd_tag;
    logic [DATA_W-1:0]   rd_data;
    logic                idle;
    logic                ewc;
    logic                wr_en;
    logic                lk_fire;
    logic                ram_en;
    logic [INDEX_W-1:0]  ram_addr;

    // Valid/ready: a lookup transfers on a rising edge where lk_valid & lk_ready;
    // updates have no ready and are either written or dropped in the cycle offered.
    assign idle     = (state_q == IDLE);
    assign ewc      = brk_n & con & wcinh_n;
    assign wr_en    = idle & upd_valid & ewc;
    assign lk_ready = idle & ~upd_valid & cclr_n;
    assign lk_fire  = lk_valid & lk_ready;
    assign ram_en   = wr_en | lk_fire;
    assign ram_addr = upd_valid ? upd_idx : lk_idx;

    mmu_cache_line_ram #(
        .AW (INDEX_W),
        .DW (TAG_W + DATA_W)
    ) u_line_ram (
        .clk   (sysclk),
        .en    (ram_en),
        .we    (wr_en),
        .addr  (ram_addr),
        .wdata ({upd_tag, upd_data}),
        .rdata ({rd_tag, rd_data})
    );

    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= CLEAR;
            sweep_cnt <= '0;
            req_q     <= '0;
        end else begin
            req_q.pend <= lk_fire;
            if (lk_fire) begin
                req_q.vld <= valid_q[lk_idx];
                req_q.tag <= MAX_TAG_W'(lk_tag);
            end
            case (state_q)
                CLEAR: begin
                    // A fresh clear request restarts the sweep, even on its last line.
                    if (!cclr_n) begin
                        sweep_cnt <= '0;
                    end else if (sweep_cnt == LAST_IDX) begin
                        state_q <= IDLE;
                    end else begin
                        sweep_cnt <= sweep_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (!cclr_n) begin
                        state_q   <= CLEAR;
                        sweep_cnt <= '0;
                    end
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

    // No reset here: the sweep that follows reset is what invalidates the lines.
    always_ff @(posedge sysclk) begin
        if (state_q == CLEAR) begin
            valid_q[sweep_cnt] <= 1'b0;
        end else if (wr_en) begin
            valid_q[upd_idx] <= 1'b1;
        end
    end

    assign busy      = (state_q == CLEAR);
    assign state     = state_q;
    assign res_valid = req_q.pend;
    assign res_hit   = req_q.pend & req_q.vld & (MAX_TAG_W'(rd_tag) == req_q.tag);
    assign res_data  = res_hit ? rd_data : '0;

`ifdef CACHE_STATS_EN
    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (res_valid) begin
            if (res_hit && hit_cnt != 32'hFFFF_FFFF) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (!res_hit && miss_cnt != 32'hFFFF_FFFF) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mmu_cache_dm_param.sv
// Self-checking bench for mmu_cache_dm_param: directed cases plus random traffic
// against a line-array reference model. Honours CACHE_STATS_EN when defined.
module tb_mmu_cache_dm_param;
    import mmu_cache_pkg::*;

    localparam int INDEX_W = 11;
    localparam int TAG_W   = 14;
    localparam int DATA_W  = 16;
    localparam int LINES   = 2**INDEX_W;

    logic               sysclk = 1'b0;
    logic               sys_rst_n;
    logic               lk_valid;
    logic               lk_ready;
    logic [INDEX_W-1:0] lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic               res_valid;
    logic               res_hit;
    logic [DATA_W-1:0]  res_data;
    logic               upd_valid;
    logic [INDEX_W-1:0] upd_idx;
    logic [TAG_W-1:0]   upd_tag;
    logic [DATA_W-1:0]  upd_data;
    logic               brk_n;
    logic               con;
    logic               wcinh_n;
    logic               cclr_n;
    logic               busy;
    cache_state_t       state;
`ifdef CACHE_STATS_EN
    logic [31:0]        hit_cnt;
    logic [31:0]        miss_cnt;
    int                 m_hits = 0;
    int                 m_miss = 0;
`endif

    // ---------------- clock / reset ----------------
    always #5 sysclk = ~sysclk;

    mmu_cache_dm_param #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W)
    ) dut (
        .sysclk    (sysclk),
        .sys_rst_n (sys_rst_n),
        .lk_valid  (lk_valid),
        .lk_ready  (lk_ready),
        .lk_idx    (lk_idx),
        .lk_tag    (lk_tag),
        .res_valid (res_valid),
        .res_hit   (res_hit),
        .res_data  (res_data),
        .upd_valid (upd_valid),
        .upd_idx   (upd_idx),
        .upd_tag   (upd_tag),
        .upd_data  (upd_data),
        .brk_n     (brk_n),
        .con       (con),
        .wcinh_n   (wcinh_n),
        .cclr_n    (cclr_n),
        .busy      (busy),
        .state     (state)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    int error_cnt = 0;
    int check_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act !== exp) begin
            error_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit                m_valid [LINES];
    logic [TAG_W-1:0]  m_tag   [LINES];
    logic [DATA_W-1:0] m_data  [LINES];
    int                clear_left;
    logic [DATA_W:0]   exp_q[$];

    function automatic logic [DATA_W:0] model_lookup(input logic [INDEX_W-1:0] idx,
                                                     input logic [TAG_W-1:0] tag);
        if (m_valid[idx] && m_tag[idx] == tag) return {1'b1, m_data[idx]};
        return '0;
    endfunction

    always @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            clear_left <= LINES;
            exp_q.delete();
        end else begin
            if (lk_valid && clear_left == 0 && !upd_valid && cclr_n) begin
                exp_q.push_back(model_lookup(lk_idx, lk_tag));
            end
            if (clear_left > 0) begin
                clear_left <= cclr_n ? clear_left - 1 : LINES;
            end else begin
                if (upd_valid && brk_n && con && wcinh_n) begin
                    m_valid[upd_idx] <= 1'b1;
                    m_tag[upd_idx]   <= upd_tag;
                    m_data[upd_idx]  <= upd_data;
                end
                if (!cclr_n) begin
                    clear_left <= LINES;
                    for (int i = 0; i < LINES; i++) m_valid[i] <= 1'b0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [DATA_W:0] cmp_e;

    always @(negedge sysclk) begin
        if (!sys_rst_n) begin
            check("rst_res_valid", res_valid, 0);
            check("rst_res_hit",   res_hit,   0);
            check("rst_res_data",  res_data,  0);
            check("rst_busy",      busy,      1);
            check("rst_lk_ready",  lk_ready,  0);
        end else begin
            check("busy", busy, clear_left > 0);
            check("lk_ready", lk_ready, clear_left == 0 && !upd_valid && cclr_n);
`ifdef CACHE_STATS_EN
            check("hit_cnt", hit_cnt, m_hits);
            check("miss_cnt", miss_cnt, m_miss);
`endif
            if (exp_q.size() > 0) begin
                cmp_e = exp_q.pop_front();
                check("res_valid", res_valid, 1);
                check("res_hit", res_hit, cmp_e[DATA_W]);
                check("res_data", res_data, cmp_e[DATA_W-1:0]);
`ifdef CACHE_STATS_EN
                if (cmp_e[DATA_W]) m_hits++; else m_miss++;
`endif
            end else begin
                check("res_valid_idle", res_valid, 0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic upd(input logic [INDEX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                       input logic [DATA_W-1:0] data);
        upd_valid = 1'b1;
        upd_idx   = idx;
        upd_tag   = tag;
        upd_data  = data;
        tick();
        upd_valid = 1'b0;
    endtask

    task automatic look(input logic [INDEX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                        input logic eh, input logic [DATA_W-1:0] ed, input string name);
        int n = 0;
        lk_valid = 1'b1;
        lk_idx   = idx;
        lk_tag   = tag;
        @(negedge sysclk);
        while (!lk_ready && n < 100) begin
            @(negedge sysclk);
            n++;
        end
        check({name, "_accept"}, lk_ready, 1);
        tick();
        lk_valid = 1'b0;
        @(negedge sysclk);
        check({name, "_valid"}, res_valid, 1);
        check({name, "_hit"}, res_hit, eh);
        check({name, "_data"}, res_data, ed);
        tick();
    endtask

    // Counts busy cycles of one sweep; optionally pulses cclr_n in the 1000th cycle.
    task automatic measure_sweep(input bit restart, output int n);
        n = 0;
        while (n < 10000) begin
            cclr_n = !(restart && n == 999);
            @(negedge sysclk);
            if (!busy) break;
            n++;
            tick();
        end
        cclr_n = 1'b1;
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        lk_valid  = 0; lk_idx = '0; lk_tag = '0;
        upd_valid = 0; upd_idx = '0; upd_tag = '0; upd_data = '0;
        brk_n = 1; con = 1; wcinh_n = 1; cclr_n = 1;
        sys_rst_n = 0;
        repeat (3) @(posedge sysclk);
        #1 sys_rst_n = 1;

        measure_sweep(1'b0, n);
        check("reset_busy_cycles", n, 2048);
        @(negedge sysclk);
        check("ready_after_clear", lk_ready, 1);
        tick();

        upd(11'h005, 14'h0123, 16'hBEEF);
        look(11'h005, 14'h0123, 1'b1, 16'hBEEF, "hit5");
        look(11'h005, 14'h0124, 1'b0, 16'h0000, "tag_miss");

        con = 0;
        upd(11'h005, 14'h0200, 16'h1111);
        upd(11'h009, 14'h0033, 16'h2222);
        con = 1;
        look(11'h005, 14'h0123, 1'b1, 16'hBEEF, "con0_keep");
        look(11'h005, 14'h0200, 1'b0, 16'h0000, "con0_newtag");
        look(11'h009, 14'h0033, 1'b0, 16'h0000, "invalid_miss");

        // Lookup idx 7 on edge N, overwrite idx 7 on edge N+1.
        upd(11'h007, 14'h0010, 16'hAAAA);
        lk_valid = 1; lk_idx = 11'h007; lk_tag = 14'h0010;
        @(negedge sysclk);
        check("rbw_ready", lk_ready, 1);
        tick();
        lk_valid = 0;
        upd_valid = 1; upd_idx = 11'h007; upd_tag = 14'h0011; upd_data = 16'hBBBB;
        @(negedge sysclk);
        check("rbw_old_valid", res_valid, 1);
        check("rbw_old_hit", res_hit, 1);
        check("rbw_old_data", res_data, 16'hAAAA);
        tick();
        upd_valid = 0;
        look(11'h007, 14'h0011, 1'b1, 16'hBBBB, "rbw_new");

        // Update and lookup offered together.
        upd_valid = 1; upd_idx = 11'h003; upd_tag = 14'h0005; upd_data = 16'h3333;
        lk_valid  = 1; lk_idx  = 11'h003; lk_tag  = 14'h0005;
        @(negedge sysclk);
        check("both_ready_low", lk_ready, 0);
        tick();
        upd_valid = 0;
        @(negedge sysclk);
        check("both_ready_high", lk_ready, 1);
        check("both_no_result", res_valid, 0);
        tick();
        lk_valid = 0;
        @(negedge sysclk);
        check("both_valid", res_valid, 1);
        check("both_hit", res_hit, 1);
        check("both_data", res_data, 16'h3333);
        tick();

        // Clear request, restarted mid-sweep.
        cclr_n = 0;
        tick();
        measure_sweep(1'b1, n);
        check("restart_busy_cycles", n, 1000 + 2048);
        look(11'h005, 14'h0123, 1'b0, 16'h0000, "cleared_miss");

        // Random traffic.
        for (int c = 0; c < 6000; c++) begin
            lk_valid  = $urandom_range(0, 1) == 1;
            upd_valid = $urandom_range(0, 3) == 0;
            lk_idx    = ($urandom_range(0, 3) == 0) ? INDEX_W'($urandom_range(0, LINES-1))
                                                    : INDEX_W'($urandom_range(0, 15));
            upd_idx   = INDEX_W'($urandom_range(0, 15));
            lk_tag    = TAG_W'($urandom_range(0, 3));
            upd_tag   = TAG_W'($urandom_range(0, 3));
            upd_data  = DATA_W'($urandom_range(0, 65535));
            brk_n     = $urandom_range(0, 7) != 0;
            con       = $urandom_range(0, 7) != 0;
            wcinh_n   = $urandom_range(0, 7) != 0;
            cclr_n    = $urandom_range(0, 1999) != 0;
            tick();
        end
        lk_valid = 0; upd_valid = 0; cclr_n = 1;
        brk_n = 1; con = 1; wcinh_n = 1;
        repeat (3) tick();
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", error_cnt, check_cnt);
        $finish;
    end

endmodule
